// File: rtl/mem_arb_pkg.sv
// Shared types for the cpu32 single-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DATA
  } gnt_id_e;

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Combinational two-way picker: returns the grant id for fetch/data eligibility.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic    fetch_el_i,
  input  logic    data_el_i,
  input  logic    fetch_prio_i,
  output gnt_id_e gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (fetch_el_i && data_el_i) begin
      gnt_o = fetch_prio_i ? GNT_FETCH : GNT_DATA;
    end else if (fetch_el_i) begin
      gnt_o = GNT_FETCH;
    end else if (data_el_i) begin
      gnt_o = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM port between fetch and load/store requesters.
// Define CPU32_ARB_FAIR_EN for alternating tie priority; default is data-wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_ack,
  output logic [DWIDTH-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_ack,
  output logic [DWIDTH-1:0] d_rdata,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_rdata
);

  arb_state_e state_q, state_d;
  gnt_id_e    gnt;
  logic       fetch_el, data_el, fetch_prio;

  // A requester is excluded in its own ack cycle; reset suppresses all grants.
  assign fetch_el = i_req && (state_q != I_BUSY) && !reset;
  assign data_el  = d_req && (state_q != D_BUSY) && !reset;

`ifdef CPU32_ARB_FAIR_EN
  logic last_grant_q, last_grant_d;  // 0 = FETCH, 1 = DATA

  assign fetch_prio = last_grant_q;

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt == GNT_FETCH) last_grant_d = 1'b0;
    else if (gnt == GNT_DATA) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= 1'b0;
    else       last_grant_q <= last_grant_d;
  end
`else
  assign fetch_prio = 1'b0;
`endif

  arb_pick2 u_pick (
    .fetch_el_i  (fetch_el),
    .data_el_i   (data_el),
    .fetch_prio_i(fetch_prio),
    .gnt_o       (gnt)
  );

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    state_d   = IDLE;
    unique case (gnt)
      GNT_FETCH: begin
        ram_addr = i_addr;
        state_d  = I_BUSY;
      end
      GNT_DATA: begin
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
        ram_we    = d_we;
        state_d   = D_BUSY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign i_ack   = (state_q == I_BUSY) && !reset;
  assign d_ack   = (state_q == D_BUSY) && !reset;
  assign i_rdata = ram_rdata;
  assign d_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences, random vs model.
module tb_mem_arbiter;

`ifdef CPU32_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, d_req, d_we, d_ack, ram_we;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // Synchronous RAM: read-first, data one cycle after the address.
  logic [31:0] mem [256];
  bit          wr  [256];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hA5A50000 ^ (a * 32'h00010003);
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_wdata;
      wr[ram_addr[7:0]]  <= 1'b1;
    end
    ram_rdata <= wr[ram_addr[7:0]] ? mem[ram_addr[7:0]] : dflt(ram_addr);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, ir; logic [31:0] ia;
    logic dr, dw; logic [31:0] da, dd;
    logic eia, eda, ewe; logic [31:0] eaddr, ewd;
    logic cir; logic [31:0] eir;
    logic cdr; logic [31:0] edr;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rst, ir, input logic [31:0] ia,
                     input logic dr, dw, input logic [31:0] da, dd,
                     input logic eia, eda, ewe, input logic [31:0] eaddr, ewd,
                     input logic cir, input logic [31:0] eir,
                     input logic cdr, input logic [31:0] edr);
    vec_t v;
    v = '{rst, ir, ia, dr, dw, da, dd, eia, eda, ewe, eaddr, ewd, cir, eir, cdr, edr};
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; i_req = v.ir; i_addr = v.ia;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
    @(negedge clk);
    chk({tag, " i_ack"}, {31'b0, i_ack}, {31'b0, v.eia});
    chk({tag, " d_ack"}, {31'b0, d_ack}, {31'b0, v.eda});
    chk({tag, " ram_we"}, {31'b0, ram_we}, {31'b0, v.ewe});
    chk({tag, " ram_addr"}, ram_addr, v.eaddr);
    chk({tag, " ram_wdata"}, ram_wdata, v.ewd);
    if (v.cir) chk({tag, " i_rdata"}, i_rdata, v.eir);
    if (v.cdr) chk({tag, " d_rdata"}, d_rdata, v.edr);
    @(posedge clk); #1;
  endtask

  // Transaction-level reference: in-flight access and memory image.
  typedef struct { bit is_data; logic [31:0] addr; logic we; } tx_t;
  tx_t         pend[$];
  logic [31:0] refmem [int];
  bit          last_data;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)] : dflt(a);
  endfunction

  localparam logic [31:0] A = 32'hDEADBEEF;
  localparam logic [31:0] B = 32'h12345678;
  localparam logic [31:0] C = 32'hC0FFEE11;

  initial begin
    reset = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    @(posedge clk); #1;

    //   rst ir ia     dr dw da     dd   | eia eda ewe eaddr ewd | cir eir | cdr edr
    row(1, 0, 0,     1, 1, 32'h10, A,   0, 0, 0, 0,      0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 1, 32'h10, A,   0, 0, 1, 32'h10, A,  0, 0, 0, 0);
    row(0, 0, 0,     1, 1, 32'h10, A,   0, 1, 0, 0,      0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 1, 32'h20, B,   0, 0, 1, 32'h20, B,  0, 0, 0, 0);
    row(0, 0, 0,     1, 1, 32'h20, B,   0, 1, 0, 0,      0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 0, 32'h20, 0,   0, 0, 0, 32'h20, 0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 0, 32'h20, 0,   0, 1, 0, 0,      0,  0, 0, 1, B);
    row(0, 1, 32'h10, 0, 0, 0,     0,   0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 0, 0, 0,     0,   1, 0, 0, 0,      0,  1, A, 0, 0);
    row(0, 1, 32'h10, 0, 0, 0,     0,   0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 0, 0, 0,     0,   1, 0, 0, 0,      0,  1, A, 0, 0);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  0, 0, 0, 32'h20, 0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  0, 1, 0, 32'h10, 0,  0, 0, 1, B);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  1, 0, 0, 32'h20, 0,  1, A, 0, 0);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  0, 1, 0, 32'h10, 0,  0, 0, 1, B);
    row(0, 1, 32'h10, 0, 0, 0,     0,   1, 0, 0, 0,      0,  1, A, 0, 0);
    row(0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0,      0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  0, 0, 0, 32'h20, 0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 1, 0, 32'h20, 0,  0, 1, 0, 32'h10, 0,  0, 0, 1, B);
    row(0, 1, 32'h10, 0, 0, 0,     0,   1, 0, 0, 0,      0,  1, A, 0, 0);
    row(0, 0, 0,     1, 0, 32'h10, 0,   0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 0, 32'h10, 0,   0, 1, 0, 0,      0,  0, 0, 1, A);
`ifdef CPU32_ARB_FAIR_EN
    row(0, 1, 32'h20, 1, 0, 32'h10, 0,  0, 0, 0, 32'h20, 0,  0, 0, 0, 0);
    row(0, 1, 32'h20, 1, 0, 32'h10, 0,  1, 0, 0, 32'h10, 0,  1, B, 0, 0);
    row(0, 0, 0,     0, 0, 0,     0,   0, 1, 0, 0,      0,  0, 0, 1, A);
`else
    row(0, 1, 32'h20, 1, 0, 32'h10, 0,  0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(0, 1, 32'h20, 1, 0, 32'h10, 0,  0, 1, 0, 32'h20, 0,  0, 0, 1, A);
    row(0, 0, 0,     0, 0, 0,     0,   1, 0, 0, 0,      0,  1, B, 0, 0);
`endif
    row(0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0,      0,  0, 0, 0, 0);

    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], $sformatf("vec%0d", k));

    // Reset in the cycle after a store grant: no ack, store still lands.
    vecs.delete();
    row(0, 0, 0,     1, 1, 32'h30, C,   0, 0, 1, 32'h30, C,  0, 0, 0, 0);
    row(1, 0, 0,     1, 1, 32'h30, C,   0, 0, 0, 0,      0,  0, 0, 0, 0);
    row(0, 0, 0,     0, 0, 0,     0,   0, 0, 0, 0,      0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 0, 32'h30, 0,   0, 0, 0, 32'h30, 0,  0, 0, 0, 0);
    row(0, 0, 0,     1, 0, 32'h30, 0,   0, 1, 0, 0,      0,  0, 0, 1, C);
    // Reset in a fetch ack cycle: fetch is re-granted from IDLE afterwards.
    row(0, 1, 32'h10, 0, 0, 0,     0,   0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(1, 1, 32'h10, 0, 0, 0,     0,   0, 0, 0, 0,      0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 0, 0, 0,     0,   0, 0, 0, 32'h10, 0,  0, 0, 0, 0);
    row(0, 1, 32'h10, 0, 0, 0,     0,   1, 0, 0, 0,      0,  1, A, 0, 0);
    for (int k = 0; k < vecs.size(); k++) apply(vecs[k], $sformatf("seq%0d", k));

    // Randomised run against the transaction model, starting from reset.
    reset = 1'b1; i_req = 0; d_req = 0;
    @(posedge clk); #1;
    begin
      bit          ia = 0, da = 0;
      logic [31:0] ia_addr = 0, da_addr = 0, da_wd = 0;
      logic        da_we = 0;
      pend.delete();
      last_data = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit          rst, e_ia, e_da, el_i, el_d, g_i, g_d, e_we;
        logic [31:0] e_addr, e_wd, e_rd;
        rst = ($urandom_range(0, 99) == 0);
        reset   = rst;
        i_req   = ia;
        i_addr  = ia ? ia_addr : $urandom;
        d_req   = da;
        d_addr  = da ? da_addr : $urandom;
        d_wdata = da ? da_wd : $urandom;
        d_we    = da ? da_we : 1'($urandom);
        @(negedge clk);
        e_ia = !rst && pend.size() > 0 && !pend[0].is_data;
        e_da = !rst && pend.size() > 0 &&  pend[0].is_data;
        e_rd = (pend.size() > 0) ? ref_rd(pend[0].addr) : '0;
        el_i = !rst && ia && !e_ia;
        el_d = !rst && da && !e_da;
        g_d  = el_d && (!el_i || !(FAIR && last_data));
        g_i  = el_i && !g_d;
        e_addr = g_i ? ia_addr : (g_d ? da_addr : '0);
        e_wd   = g_d ? da_wd : '0;
        e_we   = g_d && da_we;
        chk("rnd i_ack", {31'b0, i_ack}, {31'b0, e_ia});
        chk("rnd d_ack", {31'b0, d_ack}, {31'b0, e_da});
        chk("rnd ram_we", {31'b0, ram_we}, {31'b0, e_we});
        chk("rnd ram_addr", ram_addr, e_addr);
        chk("rnd ram_wdata", ram_wdata, e_wd);
        if (e_ia) chk("rnd i_rdata", i_rdata, e_rd);
        if (e_da && !pend[0].we) chk("rnd d_rdata", d_rdata, e_rd);
        pend.delete();
        if (rst) last_data = 1'b0;
        if (g_i) begin
          pend.push_back('{1'b0, ia_addr, 1'b0});
          last_data = 1'b0;
        end
        if (g_d) begin
          pend.push_back('{1'b1, da_addr, da_we});
          if (da_we) refmem[int'(da_addr)] = da_wd;
          last_data = 1'b1;
        end
        if (e_ia) ia = 0;
        if (e_da) da = 0;
        if (!ia && $urandom_range(0, 2) != 0) begin
          ia = 1; ia_addr = $urandom_range(0, 15);
        end
        if (!da && $urandom_range(0, 2) != 0) begin
          da = 1; da_addr = $urandom_range(0, 15); da_wd = $urandom; da_we = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
